// File: rtl/pat_buffer.sv
// Eight 32-field pattern buffers shared between a processor port and an external load/drain stream.
// Optional `PAT_BUFFER_BYPASS_EN forwards a same-field processor write straight to field_in.
module pat_buffer #(
    parameter int bufp_width   = 3,
    parameter int fieldp_width = 5,
    parameter int buffer_width = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [bufp_width-1:0]   bufp,
    input  logic [fieldp_width-1:0] fieldp,
    input  logic [fieldp_width-1:0] fieldwp,
    input  logic [buffer_width-1:0] field_out,
    input  logic                    write_en,
    output logic [buffer_width-1:0] field_in,
    input  logic                    ext_cmd_valid,
    output logic                    ext_cmd_ready,
    input  logic                    ext_cmd_load,
    input  logic [bufp_width-1:0]   ext_cmd_buf,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [buffer_width-1:0] in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [buffer_width-1:0] out_data,
    output logic                    busy
);
    localparam int AW = bufp_width + fieldp_width;
    localparam logic [fieldp_width-1:0] CNT_LAST = '1;

    typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

    state_t                  state, state_nx;
    logic [buffer_width-1:0] mem [0:(1<<AW)-1];
    logic [bufp_width-1:0]   xbuf;
    logic [fieldp_width-1:0] cnt;
    logic                    ext_free, cmd_fire, load_fire, drain_fire, drain_fetch;

    // The external side may only move while the processor is looking at a different buffer.
    assign ext_free      = (xbuf != bufp);
    assign ext_cmd_ready = reset && (state == IDLE);
    assign in_ready      = reset && (state == LOAD) && ext_free;
    assign busy          = (state != IDLE);
    assign cmd_fire      = ext_cmd_valid && ext_cmd_ready;
    assign load_fire     = in_valid && in_ready;
    assign drain_fire    = (state == DRAIN) && out_valid && out_ready;
    assign drain_fetch   = (state == DRAIN) && !out_valid && ext_free;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (cmd_fire) state_nx = ext_cmd_load ? LOAD : DRAIN;
            LOAD:    if (load_fire && cnt == CNT_LAST) state_nx = IDLE;
            DRAIN:   if (drain_fire && cnt == CNT_LAST) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            xbuf      <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            state <= state_nx;
            if (cmd_fire) begin
                xbuf <= ext_cmd_buf;
                cnt  <= '0;
            end else if (load_fire || drain_fire) begin
                cnt <= cnt + 1'b1;
            end
            // A presented word is held until taken; the next fetch waits one cycle.
            if (drain_fire) begin
                out_valid <= 1'b0;
            end else if (drain_fetch) begin
                out_valid <= 1'b1;
                out_data  <= mem[{xbuf, cnt}];
            end
        end
    end

    // Storage is never cleared; both ports target different buffers so they never collide.
    always_ff @(posedge clk) begin
        if (write_en)  mem[{bufp, fieldwp}] <= field_out;
        if (load_fire) mem[{xbuf, cnt}]     <= in_data;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            field_in <= '0;
        end else begin
`ifdef PAT_BUFFER_BYPASS_EN
            if (write_en && fieldwp == fieldp) field_in <= field_out;
            else                               field_in <= mem[{bufp, fieldp}];
`else
            field_in <= mem[{bufp, fieldp}];
`endif
        end
    end

endmodule
